pulse_train_gen: RTL and testbench
==================================

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 Parameter SHALL be: CNT_W, default 8, width of the count and phase-length fields.
REQ-002 Port SHALL be: clock  input  1  single system clock; all logic on its rising edge.
REQ-003 Port SHALL be: reset  input  1  synchronous, active-high reset.
REQ-004 Port SHALL be: start  input  1  request to launch a pulse train; sampled only in IDLE.
REQ-005 Port SHALL be: abort  input  1  terminates an active train immediately.
REQ-006 Port SHALL be: num_pulses  input  CNT_W  number of rising edges to emit.
REQ-007 Port SHALL be: high_cycles  input  CNT_W  high-phase length in cycles; 0 treated as 1.
REQ-008 Port SHALL be: low_cycles  input  CNT_W  low-phase length in cycles; 0 treated as 1.
REQ-009 Port SHALL be: d_out  output  1  registered pulse-train waveform, intended to drive an edge detector's d_in.
REQ-010 Port SHALL be: busy  output  1  high while a train is in progress.
REQ-011 Port SHALL be: done  output  1  one-cycle completion strobe.
REQ-012 Port SHALL be: edge_count  output  CNT_W  rising edges emitted in the current or last train.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, HIGH, LOW, FIN.
REQ-014 In IDLE, start=1 with num_pulses!=0 SHALL latch num_pulses, high_cycles and low_cycles, clear edge_count, and enter HIGH on the next cycle.
- Consequence: d_out=1 and busy=1 one cycle after the start is sampled.
REQ-015 In IDLE, start=1 with num_pulses=0 SHALL enter FIN directly, clear edge_count, and leave d_out low.
REQ-016 HIGH SHALL hold d_out=1 for exactly max(high_cycles,1) cycles, then enter LOW.
REQ-017 LOW SHALL hold d_out=0 for exactly max(low_cycles,1) cycles.
- At the end of LOW, the FSM SHALL enter HIGH again if pulses remain, otherwise FIN.
REQ-018 edge_count SHALL increment by 1 in the cycle d_out transitions 0->1.
- Final value SHALL equal the latched num_pulses.
REQ-019 FIN SHALL last one cycle with done=1, busy=0, d_out=0, then return to IDLE.
REQ-020 busy SHALL be 1 in HIGH and LOW only.
- A full train SHALL hold busy=1 for exactly N*(H+L) cycles, using the effective phase lengths.
REQ-021 start asserted while busy=1 or in FIN SHALL be ignored.
- Inputs changing mid-train SHALL NOT affect the active train.
REQ-022 abort=1 in HIGH or LOW SHALL force d_out=0 and enter IDLE on the next cycle.
- The aborting train SHALL NOT assert done.
- edge_count SHALL retain its value.
REQ-023 abort in IDLE or FIN SHALL have no effect.
- If start and abort are both 1 in IDLE, the start SHALL be accepted.
REQ-024 Phase counters SHALL be CNT_W wide and count down.
- Phase lengths up to 2^CNT_W-1 SHALL be supported without wrap.
REQ-025 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.

Reset
REQ-026 While reset=1 at a rising clock edge, the block SHALL enter IDLE with d_out=0, busy=0, done=0, edge_count=0, and all latched fields and counters at 0.
REQ-027 reset SHALL take priority over start and abort.
- Reset mid-train SHALL terminate the train with no done strobe.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (2-bit: IDLE=0, HIGH=1, LOW=2, FIN=3) and the default CNT_W.
REQ-029 One sub-module, phase_counter, SHALL implement a loadable down-counter with a terminal-count flag, instantiated once for the phase timer.
- The remaining-pulse counter SHALL live in the top module.

Verification
REQ-030 Scenario 1: start at cycle 0 with N=3, H=2, L=1 -> d_out=1 in cycles 1-2, 4-5, 7-8; d_out=0 in cycles 3, 6, 9; done=1 at cycle 10; edge_count=3.
REQ-031 Scenario 2: N=1, H=0, L=0 -> d_out=1 at cycle 1, 0 at cycle 2, done at cycle 3, busy high for 2 cycles.
REQ-032 Scenario 3: N=0 -> done at cycle 1; d_out never high; busy never high; edge_count=0.
REQ-033 Scenario 4: N=4, H=3, L=3 with abort at cycle 8 -> d_out=0 from cycle 9, no done, edge_count=2, IDLE at cycle 9.
REQ-034 Scenario 5: second start pulses at cycles 2 and 5 during an N=2, H=2, L=2 train -> both ignored; exactly 2 edges; done at cycle 9; a new start at cycle 10 is accepted.
REQ-035 Scenario 6: reset asserted at cycle 4 of an N=5, H=1, L=1 train -> at cycle 5 all outputs are 0 and no done is ever seen; the rising_edge detector fed by d_out reports exactly as many pulses as edge_count in every scenario.

Source files
------------

// File: rtl/pulse_train_gen_pkg.sv
// Shared definitions for the pulse train generator: FSM encoding and default field width.
package pulse_train_gen_pkg;

    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/pulse_train_gen_phase_counter.sv
// Loadable down-counter timing one HIGH or LOW phase; tc flags the last cycle of the phase.
module phase_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - CNT_W'(1);
    end

    // Count holds the cycles left in the phase including the current one.
    assign tc = (count == CNT_W'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse train generator: emits N high/low pulses with programmable phase lengths, abortable.
module pulse_train_gen
    import pulse_train_gen_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_pulses,
    input  logic [CNT_W-1:0] high_cycles,
    input  logic [CNT_W-1:0] low_cycles,
    output logic             d_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] edge_count
);

    state_t           state;
    logic [CNT_W-1:0] h_lat, l_lat, pulses_left;
    logic             ph_load, ph_dec, ph_tc;
    logic [CNT_W-1:0] ph_val;
    logic             launch;

    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    assign launch = (state == IDLE) && start && (num_pulses != '0);

    always_comb begin
        ph_load = 1'b0;
        ph_dec  = 1'b0;
        ph_val  = '0;
        case (state)
            IDLE: if (launch) begin
                ph_load = 1'b1;
                ph_val  = eff_len(high_cycles);
            end
            HIGH: if (!abort) begin
                if (ph_tc) begin
                    ph_load = 1'b1;
                    ph_val  = eff_len(l_lat);
                end else begin
                    ph_dec = 1'b1;
                end
            end
            LOW: if (!abort) begin
                if (ph_tc) begin
                    ph_load = (pulses_left != '0);
                    ph_val  = eff_len(h_lat);
                end else begin
                    ph_dec = 1'b1;
                end
            end
            default: ;
        endcase
    end

    phase_counter #(.CNT_W(CNT_W)) u_phase (
        .clock    (clock),
        .reset    (reset),
        .load     (ph_load),
        .load_val (ph_val),
        .dec      (ph_dec),
        .tc       (ph_tc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            d_out       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            edge_count  <= '0;
            h_lat       <= '0;
            l_lat       <= '0;
            pulses_left <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    h_lat <= high_cycles;
                    l_lat <= low_cycles;
                    if (num_pulses != '0) begin
                        // First rising edge happens together with entering HIGH.
                        pulses_left <= num_pulses - CNT_W'(1);
                        edge_count  <= CNT_W'(1);
                        d_out       <= 1'b1;
                        busy        <= 1'b1;
                        state       <= HIGH;
                    end else begin
                        pulses_left <= '0;
                        edge_count  <= '0;
                        done        <= 1'b1;
                        state       <= FIN;
                    end
                end
                HIGH: if (abort) begin
                    d_out <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end else if (ph_tc) begin
                    d_out <= 1'b0;
                    state <= LOW;
                end
                LOW: if (abort) begin
                    d_out <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end else if (ph_tc) begin
                    if (pulses_left != '0) begin
                        pulses_left <= pulses_left - CNT_W'(1);
                        edge_count  <= edge_count + CNT_W'(1);
                        d_out       <= 1'b1;
                        state       <= HIGH;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: trace-queue reference model, directed scenarios, random stimulus.
module tb_pulse_train_gen;

    localparam int CNT_W = 8;

    logic             clock = 1'b0;
    logic             reset, start, abort;
    logic [CNT_W-1:0] num_pulses, high_cycles, low_cycles;
    logic             d_out, busy, done;
    logic [CNT_W-1:0] edge_count;

    pulse_train_gen #(.CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .num_pulses  (num_pulses),
        .high_cycles (high_cycles),
        .low_cycles  (low_cycles),
        .d_out       (d_out),
        .busy        (busy),
        .done        (done),
        .edge_count  (edge_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic             d;
        logic             b;
        logic             dn;
        logic [CNT_W-1:0] ec;
    } obs_t;

    obs_t q[$];
    obs_t exp_o = '0;
    bit   chk_en = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [63:0] cap_d, cap_b, cap_n;
    int          cap_ec[64];

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model: an accepted start expands into the full per-cycle output trace of the train.
    always @(posedge clock) begin : model_blk
        obs_t nxt;
        int   hh, ll;
        nxt = exp_o;
        if (reset) begin
            q.delete();
            nxt = '0;
        end else if (exp_o.b && abort) begin
            q.delete();
            nxt = '{d: 1'b0, b: 1'b0, dn: 1'b0, ec: exp_o.ec};
        end else if (q.size() != 0) begin
            nxt = q.pop_front();
        end else if (exp_o.dn) begin
            nxt = '{d: 1'b0, b: 1'b0, dn: 1'b0, ec: exp_o.ec};
        end else if (start) begin
            hh = (high_cycles == 0) ? 1 : int'(high_cycles);
            ll = (low_cycles == 0) ? 1 : int'(low_cycles);
            for (int p = 1; p <= int'(num_pulses); p++) begin
                for (int i = 0; i < hh; i++) q.push_back('{d: 1'b1, b: 1'b1, dn: 1'b0, ec: CNT_W'(p)});
                for (int i = 0; i < ll; i++) q.push_back('{d: 1'b0, b: 1'b1, dn: 1'b0, ec: CNT_W'(p)});
            end
            q.push_back('{d: 1'b0, b: 1'b0, dn: 1'b1, ec: num_pulses});
            nxt = q.pop_front();
        end
        exp_o <= nxt;
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("d_out", int'(d_out), int'(exp_o.d));
            chk("busy", int'(busy), int'(exp_o.b));
            chk("done", int'(done), int'(exp_o.dn));
            chk("edge_count", int'(edge_count), int'(exp_o.ec));
        end
    end

    function automatic int rises(input logic [63:0] d, input int upto);
        int r = 0;
        for (int k = 1; k <= upto; k++) if (d[k] && !d[k-1]) r++;
        return r;
    endfunction

    task automatic wait_idle();
        int k = 0;
        while ((busy || done) && k < 3000) begin
            @(negedge clock);
            k++;
        end
        chk("idle_timeout", int'(k < 3000), 1);
        @(negedge clock);
    endtask

    // Cycle 0 is the cycle in which the launching start is held high.
    task automatic scen(input int n, input int h, input int l, input int abort_at,
                        input int reset_at, input int s1, input int s2, input int s3,
                        input int len);
        start = 1'b0; abort = 1'b0; reset = 1'b0;
        wait_idle();
        num_pulses  = CNT_W'(n);
        high_cycles = CNT_W'(h);
        low_cycles  = CNT_W'(l);
        cap_d = '0; cap_b = '0; cap_n = '0;
        for (int k = 0; k < len; k++) begin
            cap_d[k]  = d_out;
            cap_b[k]  = busy;
            cap_n[k]  = done;
            cap_ec[k] = int'(edge_count);
            start = (k == 0) || (k == s1) || (k == s2) || (k == s3);
            abort = (k == abort_at);
            reset = (k == reset_at);
            @(negedge clock);
        end
        start = 1'b0; abort = 1'b0; reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        num_pulses = '0; high_cycles = '0; low_cycles = '0;
        repeat (3) @(negedge clock);
        chk("rst_d_out", int'(d_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_edge_count", int'(edge_count), 0);
        reset = 1'b0;
        chk_en = 1'b1;

        scen(3, 2, 1, -1, -1, -1, -1, -1, 11);
        chk("s1_dout", int'(cap_d[10:0]), int'(11'b00110110110));
        chk("s1_busy", int'(cap_b[10:0]), int'(11'b01111111110));
        chk("s1_done", int'(cap_n[10:0]), int'(11'b10000000000));
        chk("s1_edges", cap_ec[10], 3);
        chk("s1_detector", rises(cap_d, 10), cap_ec[10]);

        scen(1, 0, 0, -1, -1, -1, -1, -1, 4);
        chk("s2_dout", int'(cap_d[3:0]), int'(4'b0010));
        chk("s2_busy", int'(cap_b[3:0]), int'(4'b0110));
        chk("s2_done", int'(cap_n[3:0]), int'(4'b1000));
        chk("s2_detector", rises(cap_d, 3), cap_ec[3]);

        scen(0, 5, 5, -1, -1, -1, -1, -1, 3);
        chk("s3_dout", int'(cap_d[2:0]), 0);
        chk("s3_busy", int'(cap_b[2:0]), 0);
        chk("s3_done", int'(cap_n[2:0]), int'(3'b010));
        chk("s3_edges", cap_ec[1], 0);

        scen(4, 3, 3, 8, -1, -1, -1, -1, 12);
        chk("s4_dout", int'(cap_d[11:0]), int'(12'b000110001110));
        chk("s4_done", int'(cap_n[11:0]), 0);
        chk("s4_busy9", int'(cap_b[9]), 0);
        chk("s4_edges", cap_ec[11], 2);
        chk("s4_detector", rises(cap_d, 11), cap_ec[11]);

        scen(2, 2, 2, -1, -1, 2, 5, 10, 12);
        chk("s5_dout", int'(cap_d[11:0]), int'(12'b100001100110));
        chk("s5_done", int'(cap_n[11:0]), int'(12'b001000000000));
        chk("s5_edges", cap_ec[9], 2);
        chk("s5_detector", rises(cap_d, 9), cap_ec[9]);
        chk("s5_restart_busy", int'(cap_b[11:10]), int'(2'b10));

        scen(5, 1, 1, -1, 4, -1, -1, -1, 11);
        chk("s6_pre_edges", cap_ec[4], 2);
        chk("s6_outs5", int'({cap_d[5], cap_b[5], cap_n[5]}), 0);
        chk("s6_edges5", cap_ec[5], 0);
        chk("s6_dout_after", int'(cap_d[10:5]), 0);
        chk("s6_no_done", int'(cap_n[10:0]), 0);

        wait_idle();
        for (int c = 0; c < 4000; c++) begin
            reset       = ($urandom_range(0, 299) == 0);
            start       = ($urandom_range(0, 3) == 0);
            abort       = ($urandom_range(0, 39) == 0);
            num_pulses  = CNT_W'($urandom_range(0, 5));
            high_cycles = CNT_W'($urandom_range(0, 4));
            low_cycles  = CNT_W'($urandom_range(0, 4));
            if ($urandom_range(0, 149) == 0) begin
                num_pulses = CNT_W'(1);
                if ($urandom_range(0, 1) == 0) high_cycles = '1;
                else low_cycles = '1;
            end
            @(negedge clock);
        end
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (5) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
